dft64_seq: RTL and testbench
============================

# dft64_seq

Sequencer for the 64-point DFT datapath. It accepts eight 8-sample rows over a valid/ready handshake and drives the fft8 input once per row. It generates the per-lane twiddle start/step values aligned with the fft8 output, gates accumulation of the eight complex-multiplier results, and pulses `done` once per 64-point frame. It sits between the sample source and the fft8 + 8x complexmultiplier + accumulator datapath.

## Interface
Parameters:
- `FFT_LAT`, 3, fft8 latency in cycles, from `fft_valid` to its result valid; must be ≥ 1.
- `CM_LAT`, 2, complexmultiplier latency in cycles, from twiddle/valid to `cm_valid`.
- `TO_CYC`, 32, watchdog limit in cycles (only with the watchdog macro).

Ports:
- `clk`  in  1  rising-edge clock
- `sreset`  in  1  reset: synchronous, active-high
- `in_valid`  in  1  row available
- `in_ready`  out  1  sequencer can accept a row
- `in_samples`  in  8x16  row samples
- `fft_valid`  out  1  one-cycle strobe to fft8 `isValid`
- `fft_x`  out  8x16  registered row to fft8 `x`
- `tw_start`  out  8x6  per-lane twiddle start index
- `tw_step`  out  8x6  per-lane twiddle step
- `tw_valid`  out  1  twiddles valid this cycle (aligned with the fft8 result)
- `cm_valid`  in  1  lane-0 multiplier `resultValid`
- `acc_clr`  out  1  one-cycle clear of accumulators at frame start
- `acc_en`  out  1  accumulate enable
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle frame-complete pulse
- `frame_cnt`  out  8  completed frames; wraps at 255→0
- `err`  out  1  one-cycle watchdog pulse (tied 0 when the watchdog is not compiled in)

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
  - **IDLE:** `in_ready` = 1. On accept (`in_valid & in_ready`): latch `fft_x` and set `row` = 0. Pulse `acc_clr` and `fft_valid` next cycle. Clear `res_cnt`. Go to ISSUE.
  - **ISSUE:** `in_ready` = 1. Each accept latches the row and pulses `fft_valid` next cycle, then increments `row`. When row 7 is accepted, go to DRAIN.
  - **DRAIN:** `in_ready` = 0. When `res_cnt` reaches 8, go to DONE.
  - **DONE:** pulse `done`, increment `frame_cnt`, return to IDLE.
- `row` is 3 bits. Each issued row pushes {1, `row`} into a delay line of `FFT_LAT` stages. The delay-line head drives `tw_valid`, and its row r gives, for lane j:
  - `tw_start[j]` = (r*8*j) mod 64
  - `tw_step[j]` = (r*j) mod 64
- Twiddle arithmetic is unsigned and truncated to 6 bits. When `tw_valid` = 0, `tw_start` and `tw_step` are 0.
- `acc_en` = `cm_valid` while in ISSUE or DRAIN. `res_cnt` increments on the same condition and saturates at 8. `cm_valid` in IDLE or DONE is ignored.
- An accept and a `cm_valid` in the same cycle are both processed.
- `busy` = 1 in ISSUE, DRAIN and DONE.
- Reset mid-frame: all state clears, the delay line is flushed, and in-flight results arriving after reset are ignored.

## Timing
- Reset values:
  - `in_ready` = 1 (IDLE).
  - All other outputs are 0: `fft_valid`, `fft_x`, `tw_*`, `tw_valid`, `acc_clr`, `acc_en`, `busy`, `done`, `frame_cnt`, `err`.
- Accept at cycle t:
  - `fft_valid` and `fft_x` at t+1.
  - `tw_valid` and twiddles at t+1+`FFT_LAT`.
  - `cm_valid` is expected at t+1+`FFT_LAT`+`CM_LAT`.
- Last row accepted at t gives `done` at t+`FFT_LAT`+`CM_LAT`+2 (t+7 with defaults).
- `fft_x` holds until the next accept. Back-to-back rows are one per cycle.
- Next-frame acceptance resumes the cycle after `done`.

## Configuration
- `DFT64_SEQ_WATCHDOG_EN` defined:
  - In DRAIN, a counter resets on each `cm_valid` and otherwise increments.
  - If it reaches `TO_CYC`: pulse `err` for one cycle, flush the delay line, go to IDLE without `done`, and leave `frame_cnt` unchanged.
- Macro undefined: no counter, DRAIN waits indefinitely, and `err` is constant 0.

## Test plan
- **Single frame, `in_valid` held high (defaults):**
  - 8 accepts on consecutive cycles, t0..t0+7.
  - Bench returns `cm_valid` `CM_LAT` cycles after each `tw_valid`.
  - Expect `done` at t0+14, `frame_cnt` = 1, `acc_clr` at t0+1 only, `acc_en` high for 8 cycles.
- **Row-3 twiddles:**
  - Expect `tw_start` = {0,24,48,8,32,56,16,40}.
  - Expect `tw_step` = {0,3,6,9,12,15,18,21}.
  - Both appear exactly 3 cycles after row 3's `fft_valid`.
- **Gapped input (`in_valid` every third cycle):** 8 `fft_valid` pulses each one cycle after an accept; rows 0..7 in order; one `done`.
- **Reset mid-frame (after row 4):**
  - All outputs return to reset values and `in_ready` = 1.
  - Late `cm_valid` pulses give `acc_en` = 0.
  - A fresh full frame then completes with `frame_cnt` = 1.
- **Watchdog (macro on, `TO_CYC` = 32):** withhold `cm_valid` after 5 results; expect an `err` pulse 32 cycles later, no `done`, `frame_cnt` unchanged, state IDLE.
- **Counter wrap:** 256 frames back-to-back; `frame_cnt` wraps 255→0 and `in_ready` is low only in DRAIN/DONE.

Source files
------------

// File: rtl/dft64_seq_if.sv
// dft64_seq_if: row-input valid/ready handshake for dft64_seq.
// The source drives the row; the sequencer answers with ready.
interface dft64_seq_if;
    logic             in_valid;
    logic             in_ready;
    logic [7:0][15:0] in_samples;

    modport master (
        output in_valid,
        output in_samples,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_samples,
        output in_ready
    );
endinterface

// File: rtl/dft64_seq.sv
// dft64_seq: row sequencer for the 64-point DFT datapath.
// Define DFT64_SEQ_WATCHDOG_EN to build the DRAIN-stall watchdog.
module dft64_seq #(
    parameter int FFT_LAT = 3,
    parameter int CM_LAT  = 2,
    parameter int TO_CYC  = 32
) (
    input  logic             clk,
    input  logic             sreset,
    dft64_seq_if.slave       in_if,
    output logic             fft_valid,
    output logic [7:0][15:0] fft_x,
    output logic [7:0][5:0]  tw_start,
    output logic [7:0][5:0]  tw_step,
    output logic             tw_valid,
    input  logic             cm_valid,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             busy,
    output logic             done,
    output logic [7:0]       frame_cnt,
    output logic             err
);

    if (FFT_LAT < 1 || CM_LAT < 0 || TO_CYC < 1) begin : g_bad_cfg
        $error("dft64_seq: bad latency or timeout parameter");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]              row;
    logic [2:0]              fft_row;
    logic [3:0]              res_cnt;
    logic [3:0]              res_nxt;
    logic [FFT_LAT-1:0]      dl_v;
    logic [FFT_LAT-1:0][2:0] dl_r;
    logic [5:0]              head_r;
    logic                    accept;
    logic                    res_inc;
    logic                    wd_hit;

    assign in_if.in_ready = (state == IDLE) || (state == ISSUE);
    assign accept  = in_if.in_valid && in_if.in_ready;
    assign res_inc = cm_valid && ((state == ISSUE) || (state == DRAIN));
    assign acc_en  = res_inc;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = wd_hit;

    always_comb begin
        res_nxt = res_cnt;
        if (state == IDLE && accept) begin
            res_nxt = 4'd0;
        end else if (res_inc && res_cnt != 4'd8) begin
            res_nxt = res_cnt + 4'd1;
        end
    end

    // DONE is entered on the edge that lands the eighth result.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (accept && row == 3'd7) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (res_nxt == 4'd8) state_nxt = DONE;
                else if (wd_hit) state_nxt = IDLE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state     <= IDLE;
            row       <= '0;
            fft_row   <= '0;
            res_cnt   <= '0;
            fft_valid <= 1'b0;
            fft_x     <= '0;
            acc_clr   <= 1'b0;
            frame_cnt <= '0;
            dl_v      <= '0;
            dl_r      <= '0;
        end else begin
            state     <= state_nxt;
            res_cnt   <= res_nxt;
            fft_valid <= accept;
            acc_clr   <= accept && (state == IDLE);
            if (accept) begin
                fft_x   <= in_if.in_samples;
                fft_row <= (state == IDLE) ? 3'd0 : row;
                row     <= (state == IDLE) ? 3'd1 : row + 3'd1;
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            dl_v[0] <= fft_valid && !wd_hit;
            dl_r[0] <= fft_row;
            for (int i = 1; i < FFT_LAT; i++) begin
                dl_v[i] <= dl_v[i-1] && !wd_hit;
                dl_r[i] <= dl_r[i-1];
            end
        end
    end

    assign tw_valid = dl_v[FFT_LAT-1];
    assign head_r   = {3'b000, dl_r[FFT_LAT-1]};

    // r*8*j mod 64 is just the low 3 bits of r*j shifted up by 3.
    always_comb begin
        logic [5:0] prod;
        prod = '0;
        for (int j = 0; j < 8; j++) begin
            prod        = head_r * 6'(j);
            tw_step[j]  = tw_valid ? prod : 6'd0;
            tw_start[j] = tw_valid ? {prod[2:0], 3'b000} : 6'd0;
        end
    end

`ifdef DFT64_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TO_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (sreset || state != DRAIN || cm_valid) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_hit = (state == DRAIN) && !cm_valid
                 && (wd_cnt == WD_W'(TO_CYC - 1));
`else
    assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dft64_seq.sv
// tb_dft64_seq: directed bench for the dft64_seq row sequencer.
// Build with DFT64_SEQ_WATCHDOG_EN to exercise the watchdog path.
module tb_dft64_seq;

    localparam int FFT_LAT = 3;
    localparam int CM_LAT  = 2;
    localparam int TO_CYC  = 32;

    localparam logic [47:0] ROW3_ST =
        {6'd40, 6'd16, 6'd56, 6'd32, 6'd8, 6'd48, 6'd24, 6'd0};
    localparam logic [47:0] ROW3_SP =
        {6'd21, 6'd18, 6'd15, 6'd12, 6'd9, 6'd6, 6'd3, 6'd0};
    localparam logic [47:0] ROW7_ST =
        {6'd8, 6'd16, 6'd24, 6'd32, 6'd40, 6'd48, 6'd56, 6'd0};
    localparam logic [47:0] ROW7_SP =
        {6'd49, 6'd42, 6'd35, 6'd28, 6'd21, 6'd14, 6'd7, 6'd0};

    logic             clk = 1'b0;
    logic             sreset;
    logic             fft_valid;
    logic [7:0][15:0] fft_x;
    logic [7:0][5:0]  tw_start;
    logic [7:0][5:0]  tw_step;
    logic             tw_valid;
    logic             cm_valid;
    logic             acc_clr;
    logic             acc_en;
    logic             busy;
    logic             done;
    logic [7:0]       frame_cnt;
    logic             err;

    dft64_seq_if bus ();

    dft64_seq #(
        .FFT_LAT (FFT_LAT),
        .CM_LAT  (CM_LAT),
        .TO_CYC  (TO_CYC)
    ) dut (
        .clk       (clk),
        .sreset    (sreset),
        .in_if     (bus.slave),
        .fft_valid (fft_valid),
        .fft_x     (fft_x),
        .tw_start  (tw_start),
        .tw_step   (tw_step),
        .tw_valid  (tw_valid),
        .cm_valid  (cm_valid),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Multiplier model: echo tw_valid CM_LAT cycles later.
    logic [CM_LAT-1:0] sh = '0;
    int   cm_left  = 0;
    logic cm_force = 1'b0;

    always @(negedge clk) sh = {sh[CM_LAT-2:0], tw_valid};

    always @(posedge clk) begin
        #1;
        cm_valid = (sh[CM_LAT-1] && cm_left != 0) || cm_force;
        if (sh[CM_LAT-1] && cm_left > 0) cm_left--;
    end

    int          acc_q[$];
    int          fv_q[$];
    logic [15:0] fx_q[$];
    int          tw_q[$];
    logic [47:0] ts_q[$];
    logic [47:0] tp_q[$];
    int          done_q[$];
    int          clr_q[$];
    int          err_q[$];
    int          cm_q[$];
    int          n_acc_en;
    int          n_nrdy;
    int          n_rdy_bad;
    int          n_wrap;
    logic [7:0]  prev_fc = '0;

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (fft_valid) begin
            fv_q.push_back(cyc);
            fx_q.push_back(fft_x[0]);
        end
        if (tw_valid) begin
            tw_q.push_back(cyc);
            ts_q.push_back(tw_start);
            tp_q.push_back(tw_step);
        end
        if (done) done_q.push_back(cyc);
        if (acc_clr) clr_q.push_back(cyc);
        if (err) err_q.push_back(cyc);
        if (cm_valid) cm_q.push_back(cyc);
        if (acc_en) n_acc_en++;
        if (!bus.in_ready) n_nrdy++;
        if (!bus.in_ready && !busy) n_rdy_bad++;
        if (prev_fc == 8'd255 && frame_cnt == 8'd0) n_wrap++;
        prev_fc = frame_cnt;
    end

    task automatic clear_log();
        acc_q.delete();
        fv_q.delete();
        fx_q.delete();
        tw_q.delete();
        ts_q.delete();
        tp_q.delete();
        done_q.delete();
        clr_q.delete();
        err_q.delete();
        cm_q.delete();
        n_acc_en  = 0;
        n_nrdy    = 0;
        n_rdy_bad = 0;
        n_wrap    = 0;
    endtask

    function automatic int qat(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sreset       = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) step();
        sreset = 1'b0;
    endtask

    task automatic set_row(int r);
        for (int k = 0; k < 8; k++) begin
            bus.in_samples[k] = 16'(r * 256 + k * 17);
        end
    endtask

    task automatic send_rows(int n, int gap);
        for (int r = 0; r < n; r++) begin
            bus.in_valid = 1'b1;
            set_row(r);
            step();
            bus.in_valid = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic wait_done(int n, int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (done_q.size() < n) begin
            check("done_timeout", done_q.size(), n);
        end
        repeat (3) step();
    endtask

    int t0;
    int last_cm;
    logic [7:0] fc0;

    initial begin
        sreset         = 1'b1;
        cm_valid       = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_samples = '0;
        do_reset();

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_fft_valid", fft_valid, 0);
        check("rst_fft_x", fft_x[0], 0);
        check("rst_tw_valid", tw_valid, 0);
        check("rst_tw_start", tw_start, 0);
        check("rst_tw_step", tw_step, 0);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_acc_en", acc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err", err, 0);

        // Back-to-back frame.
        cm_left = 1 << 30;
        clear_log();
        t0 = cyc;
        send_rows(8, 0);
        wait_done(1, 40);
        check("f1_accepts", acc_q.size(), 8);
        check("f1_acc_last", qat(acc_q, 7), t0 + 7);
        check("f1_fv_count", fv_q.size(), 8);
        check("f1_fv_first", qat(fv_q, 0), t0 + 1);
        check("f1_fv_last", qat(fv_q, 7), t0 + 8);
        check("f1_done_cnt", done_q.size(), 1);
        check("f1_done_cyc", qat(done_q, 0), t0 + 14);
        check("f1_frame_cnt", frame_cnt, 1);
        check("f1_clr_cnt", clr_q.size(), 1);
        check("f1_clr_cyc", qat(clr_q, 0), t0 + 1);
        check("f1_acc_en", n_acc_en, 8);
        check("f1_tw_count", tw_q.size(), 8);
        check("f1_row3_x", (fx_q.size() > 3) ? fx_q[3] : 'x,
              16'h0300);
        check("f1_row3_tw_cyc", qat(tw_q, 3), qat(fv_q, 3) + 3);
        check("f1_row3_start", (ts_q.size() > 3) ? ts_q[3] : 'x,
              ROW3_ST);
        check("f1_row3_step", (tp_q.size() > 3) ? tp_q[3] : 'x,
              ROW3_SP);
        check("f1_row7_start", (ts_q.size() > 7) ? ts_q[7] : 'x,
              ROW7_ST);
        check("f1_row7_step", (tp_q.size() > 7) ? tp_q[7] : 'x,
              ROW7_SP);
        check("f1_idle_ready", bus.in_ready, 1);
        check("f1_idle_tw", tw_start, 0);

        // Gapped input: one row every third cycle.
        clear_log();
        send_rows(8, 2);
        wait_done(1, 60);
        check("gap_fv_count", fv_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gap_fv_lag%0d", i),
                  qat(fv_q, i) - qat(acc_q, i), 1);
            check($sformatf("gap_row%0d", i),
                  (fx_q.size() > i) ? fx_q[i] : 'x,
                  16'(i * 256));
        end
        check("gap_done_cnt", done_q.size(), 1);
        check("gap_frame_cnt", frame_cnt, 2);

        // Reset after row 4 with rows still in flight.
        clear_log();
        send_rows(5, 0);
        step();
        do_reset();
        check("mid_in_ready", bus.in_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_frame_cnt", frame_cnt, 0);
        check("mid_fft_valid", fft_valid, 0);
        check("mid_fft_x", fft_x[0], 0);
        check("mid_tw_valid", tw_valid, 0);
        check("mid_acc_clr", acc_clr, 0);
        clear_log();
        @(negedge clk) cm_force = 1'b1;
        @(negedge clk) cm_force = 1'b0;
        repeat (10) step();
        check("mid_late_acc_en", n_acc_en, 0);
        check("mid_flushed_tw", tw_q.size(), 0);
        check("mid_no_done", done_q.size(), 0);
        clear_log();
        send_rows(8, 0);
        wait_done(1, 40);
        check("mid_fresh_done", done_q.size(), 1);
        check("mid_fresh_acc_en", n_acc_en, 8);
        check("mid_fresh_fc", frame_cnt, 1);

        // Results stop after five rows.
        clear_log();
        fc0     = frame_cnt;
        cm_left = 5;
        send_rows(8, 0);
`ifdef DFT64_SEQ_WATCHDOG_EN
        for (int k = 0; k < 80 && err_q.size() == 0; k++) step();
        repeat (3) step();
        last_cm = qat(cm_q, cm_q.size() - 1);
        check("wd_cm_count", cm_q.size(), 5);
        check("wd_err_cnt", err_q.size(), 1);
        check("wd_err_cyc", qat(err_q, 0), last_cm + TO_CYC);
        check("wd_no_done", done_q.size(), 0);
        check("wd_frame_cnt", frame_cnt, fc0);
        check("wd_idle_ready", bus.in_ready, 1);
        check("wd_idle_busy", busy, 0);
        check("wd_tw_flushed", tw_valid, 0);
`else
        repeat (60) step();
        check("stall_cm_count", cm_q.size(), 5);
        check("stall_no_done", done_q.size(), 0);
        check("stall_no_err", err_q.size(), 0);
        check("stall_busy", busy, 1);
        check("stall_not_ready", bus.in_ready, 0);
        check("stall_frame_cnt", frame_cnt, fc0);
`endif

        // 256 frames with in_valid held high.
        do_reset();
        clear_log();
        cm_left      = 1 << 30;
        bus.in_valid = 1'b1;
        set_row(5);
        for (int k = 0; k < 5000 && done_q.size() < 256; k++) step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("wrap_done_cnt", done_q.size(), 256);
        check("wrap_frame_cnt", frame_cnt, 0);
        check("wrap_seen", n_wrap, 1);
        check("wrap_acc_en", n_acc_en, 2048);
        check("wrap_not_ready", n_nrdy, 256 * 7);
        check("wrap_ready_bad", n_rdy_bad, 0);
        check("wrap_no_err", err_q.size(), 0);
        check("wrap_idle_ready", bus.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
